// File: rtl/goertzel_multibin_if.sv
// Sample-in / power-out handshake bundle for goertzel_multibin.
// Latency: none, wires only.
// Backpressure: s_ready throttles the sample source; m_ready stalls result delivery.
// Signals: s_valid/s_ready/s_data carry samples towards the estimator;
//          m_valid/m_ready/m_bin/m_power carry one power word per bin back out.
// The slave modport is the estimator side; master is the producer/consumer side.
interface goertzel_multibin_if #(
    parameter int DW = 32,
    parameter int BW = 1
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [BW-1:0] m_bin;
    logic [DW-1:0] m_power;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_bin, m_power
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_bin, m_power
    );
endinterface

// File: rtl/goertzel_multibin.sv
// Multi-bin Goertzel power estimator on one time-shared signed multiplier.
// Latency: first result NBINS+6 cycles after the last sample; further bins 7 cycles apart.
// Backpressure: s_ready high only in ACCUM (one sample per NBINS+1 cycles); OUT holds until m_ready.
// Ports: clk/rstn (async active-low); start latches ns_i/ns_coef_i and begins a block;
//        alpha_i/cw_re_i/cw_im_i hold per-bin coefficients (bin k at [k*DW +: DW]);
//        io carries the sample and result handshakes; busy/done/ovf report status.
// Optional macro GOERTZEL_SATURATE_EN: saturating sums/squares with sticky ovf; otherwise wrap and ovf=0.
module goertzel_multibin #(
    parameter int DW    = 32,
    parameter int FW    = 16,
    parameter int NBINS = 4,
    parameter int NSW   = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [NSW-1:0]      ns_i,
    input  logic [DW-1:0]       ns_coef_i,
    input  logic [NBINS*DW-1:0] alpha_i,
    input  logic [NBINS*DW-1:0] cw_re_i,
    input  logic [NBINS*DW-1:0] cw_im_i,
    goertzel_multibin_if.slave  io,
    output logic                busy,
    output logic                done,
    output logic                ovf
);
    localparam int KW = (NBINS > 1) ? $clog2(NBINS) : 1;
    localparam int PW = 2 * DW;
    localparam int SW = DW + 2;

    typedef enum logic [3:0] {
        IDLE, ACCUM, UPDATE, MUL_RE, SCL_RE, SQ_RE, MUL_IM, SCL_IM, SQ_IM, OUT
    } state_t;

    state_t          state_q, state_d;
    logic [NSW-1:0]  ns_q, cnt_q, cnt_inc;
    logic [DW-1:0]   coef_q, x_q, re_q, im_q, acc_q;
    logic [KW-1:0]   k_q;
    logic [DW-1:0]   v1_q [NBINS];
    logic [DW-1:0]   v2_q [NBINS];
    logic            done_q, ovf_q;

    logic [DW-1:0]   alpha_k, cwre_k, cwim_k, v1_k, v2_k;
    logic [DW-1:0]   mul_a, mul_b, mul_r;
    logic [PW-1:0]   prod;
    logic [SW-1:0]   upd_sum, acc_sum;
    logic [DW-1:0]   upd_val, sq_val, acc_val;
    logic            upd_ovf, sq_ovf, acc_ovf;
    logic            last_k;

    assign alpha_k = alpha_i[k_q*DW +: DW];
    assign cwre_k  = cw_re_i[k_q*DW +: DW];
    assign cwim_k  = cw_im_i[k_q*DW +: DW];
    assign v1_k    = v1_q[k_q];
    assign v2_k    = v2_q[k_q];
    assign last_k  = (k_q == KW'(NBINS - 1));
    assign cnt_inc = cnt_q + NSW'(1);

    // Single shared multiplier; operand pair chosen by the current step.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            UPDATE: begin mul_a = alpha_k; mul_b = v1_k;   end
            MUL_RE: begin mul_a = v1_k;    mul_b = cwre_k; end
            SCL_RE: begin mul_a = re_q;    mul_b = coef_q; end
            SQ_RE:  begin mul_a = re_q;    mul_b = re_q;   end
            MUL_IM: begin mul_a = v1_k;    mul_b = cwim_k; end
            SCL_IM: begin mul_a = im_q;    mul_b = coef_q; end
            SQ_IM:  begin mul_a = im_q;    mul_b = im_q;   end
            default: ;
        endcase
    end

    // Low 2*DW bits of the product of sign-extended operands equal the signed product.
    assign prod  = {{DW{mul_a[DW-1]}}, mul_a} * {{DW{mul_b[DW-1]}}, mul_b};
    assign mul_r = prod[FW+DW-1:FW];

    // Two guard bits keep x + a*v1 - v2 exact before the wrap/saturate decision.
    assign upd_sum = {{2{x_q[DW-1]}}, x_q} + {{2{mul_r[DW-1]}}, mul_r} - {{2{v2_k[DW-1]}}, v2_k};
    assign acc_sum = {{2{acc_q[DW-1]}}, acc_q} + {{2{sq_val[DW-1]}}, sq_val};

`ifdef GOERTZEL_SATURATE_EN
    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

    // Sum fits in DW bits only when the top three bits agree.
    function automatic logic sum_big(input logic [SW-1:0] s);
        return !((s[SW-1] == s[SW-2]) && (s[SW-2] == s[DW-1]));
    endfunction

    function automatic logic [DW-1:0] sum_sat(input logic [SW-1:0] s);
        if (sum_big(s)) return s[SW-1] ? SMIN : SMAX;
        return s[DW-1:0];
    endfunction

    // A square is never negative; anything above bit FW+DW-2 exceeds the positive limit.
    assign sq_ovf  = |prod[PW-1:FW+DW-1];
    assign sq_val  = sq_ovf ? SMAX : mul_r;
    assign upd_ovf = sum_big(upd_sum);
    assign upd_val = sum_sat(upd_sum);
    assign acc_ovf = sum_big(acc_sum);
    assign acc_val = sum_sat(acc_sum);
`else
    assign sq_ovf  = 1'b0;
    assign sq_val  = mul_r;
    assign upd_ovf = 1'b0;
    assign upd_val = upd_sum[DW-1:0];
    assign acc_ovf = 1'b0;
    assign acc_val = acc_sum[DW-1:0];
`endif

    logic unused_ok;
    assign unused_ok = ^{prod[FW-1:0], prod[PW-1:FW+DW], upd_sum[SW-1:DW], acc_sum[SW-1:DW]};

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = (ns_i == '0) ? MUL_RE : ACCUM;
            ACCUM:  if (io.s_valid) state_d = UPDATE;
            UPDATE: if (last_k) state_d = (cnt_inc == ns_q) ? MUL_RE : ACCUM;
            MUL_RE: state_d = SCL_RE;
            SCL_RE: state_d = SQ_RE;
            SQ_RE:  state_d = MUL_IM;
            MUL_IM: state_d = SCL_IM;
            SCL_IM: state_d = SQ_IM;
            SQ_IM:  state_d = OUT;
            OUT:    if (io.m_ready) state_d = last_k ? IDLE : MUL_RE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; m_bin/m_power read zero outside OUT so partial results never leak.
    always_comb begin
        io.s_ready = (state_q == ACCUM);
        io.m_valid = (state_q == OUT);
        io.m_bin   = (state_q == OUT) ? k_q : '0;
        io.m_power = (state_q == OUT) ? acc_q : '0;
        busy       = (state_q != IDLE);
        done       = done_q;
        ovf        = ovf_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ns_q   <= '0;
            coef_q <= '0;
            cnt_q  <= '0;
            k_q    <= '0;
            x_q    <= '0;
            re_q   <= '0;
            im_q   <= '0;
            acc_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < NBINS; i++) begin
                v1_q[i] <= '0;
                v2_q[i] <= '0;
            end
        end else begin
            done_q <= (state_q == OUT) && io.m_ready && last_k;
            case (state_q)
                IDLE: if (start) begin
                    ns_q   <= ns_i;
                    coef_q <= ns_coef_i;
                    cnt_q  <= '0;
                    k_q    <= '0;
                    ovf_q  <= 1'b0;
                    for (int i = 0; i < NBINS; i++) begin
                        v1_q[i] <= '0;
                        v2_q[i] <= '0;
                    end
                end
                ACCUM: if (io.s_valid) begin
                    x_q <= io.s_data;
                    k_q <= '0;
                end
                UPDATE: begin
                    v1_q[k_q] <= upd_val;
                    v2_q[k_q] <= v1_k;
                    ovf_q     <= ovf_q | upd_ovf;
                    if (last_k) begin
                        k_q   <= '0;
                        cnt_q <= cnt_inc;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                MUL_RE: re_q  <= mul_r - v2_k;
                SCL_RE: re_q  <= mul_r;
                SQ_RE: begin
                    acc_q <= sq_val;
                    ovf_q <= ovf_q | sq_ovf;
                end
                MUL_IM: im_q  <= mul_r;
                SCL_IM: im_q  <= mul_r;
                SQ_IM: begin
                    acc_q <= acc_val;
                    ovf_q <= ovf_q | sq_ovf | acc_ovf;
                end
                OUT: if (io.m_ready && !last_k) k_q <= k_q + KW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_goertzel_multibin.sv
// Directed bench for goertzel_multibin with NBINS=2, DW=32, FW=16.
// Latency: checks first result after NBINS+6 edges and 7-cycle bin-to-bin spacing.
// Backpressure: holds m_ready low to confirm OUT keeps its word stable.
module tb_goertzel_multibin;
    localparam int DW = 32, FW = 16, NBINS = 2, NSW = 16, BW = 1;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                start = 1'b0;
    logic [NSW-1:0]      ns_i = '0;
    logic [DW-1:0]       ns_coef_i = 32'h0000_4000;
    logic [NBINS*DW-1:0] alpha_i = {32'h0000_0000, 32'h0002_0000};
    logic [NBINS*DW-1:0] cw_re_i = {32'h0000_0000, 32'h0001_0000};
    logic [NBINS*DW-1:0] cw_im_i = {32'h0001_0000, 32'h0000_0000};
    logic                busy, done, ovf;

    goertzel_multibin_if #(.DW(DW), .BW(BW)) bus ();

    goertzel_multibin #(.DW(DW), .FW(FW), .NBINS(NBINS), .NSW(NSW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .ns_i(ns_i), .ns_coef_i(ns_coef_i),
        .alpha_i(alpha_i), .cw_re_i(cw_re_i), .cw_im_i(cw_im_i), .io(bus),
        .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit model_ovf;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [NSW-1:0] ns);
        ns_i  = ns;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns with the sample handshaken, sampling #1 after that edge.
    task automatic send_sample(input logic [DW-1:0] x);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = x;
        while (!bus.s_ready && n < 50) begin tick(); n++; end
        if (!bus.s_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL s_ready_timeout: s_ready=%b after %0d cycles, required 1", bus.s_ready, n);
        end
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.m_valid && n < 100) begin tick(); n++; end
        if (!bus.m_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL m_valid_timeout: m_valid=%b after %0d cycles, required 1", bus.m_valid, n);
        end
    endtask

    task automatic take();
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
    endtask

    // Reference arithmetic: Q16.16 truncating multiply, DW-bit wrap or saturation.
    function automatic logic [31:0] mq(input logic [31:0] a, input logic [31:0] b);
        longint pa, pb, p;
        pa = $signed(a);
        pb = $signed(b);
        p  = pa * pb;
        return p[47:16];
    endfunction

    function automatic logic [31:0] add_s(input longint s);
`ifdef GOERTZEL_SATURATE_EN
        if (s > 64'sd2147483647)  begin model_ovf = 1'b1; return 32'h7FFF_FFFF; end
        if (s < -64'sd2147483648) begin model_ovf = 1'b1; return 32'h8000_0000; end
`endif
        return s[31:0];
    endfunction

    function automatic logic [31:0] sq(input logic [31:0] r);
        longint pr, p;
        pr = $signed(r);
        p  = pr * pr;
`ifdef GOERTZEL_SATURATE_EN
        if ((p >>> 16) > 64'sd2147483647) begin model_ovf = 1'b1; return 32'h7FFF_FFFF; end
`endif
        return p[47:16];
    endfunction

    function automatic logic [31:0] model_bin(input logic [31:0] al, input logic [31:0] cr,
                                              input logic [31:0] ci, input logic [31:0] x,
                                              input int ns, input logic [31:0] coef);
        logic [31:0] v1, v2, t, re, im, acc;
        longint lx, lm, lv;
        v1 = '0; v2 = '0;
        for (int i = 0; i < ns; i++) begin
            lx = $signed(x); lm = $signed(mq(al, v1)); lv = $signed(v2);
            t  = add_s(lx + lm - lv);
            v2 = v1;
            v1 = t;
        end
        re  = mq(v1, cr) - v2;
        re  = mq(re, coef);
        acc = sq(re);
        im  = mq(v1, ci);
        im  = mq(im, coef);
        lx  = $signed(acc);
        lm  = $signed(sq(im));
        acc = add_s(lx + lm);
        return acc;
    endfunction

    task automatic test_reset();
        tick(); tick();
        if (bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
        n_cmp++;
        if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid: got %b want 0", bus.m_valid); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++;
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        n_cmp++;
        if (bus.m_power !== 32'h0) begin n_bad++; $display("FAIL rst_m_power: got %h want 0", bus.m_power); end
        n_cmp++;
        if (bus.m_bin !== 1'b0) begin n_bad++; $display("FAIL rst_m_bin: got %h want 0", bus.m_bin); end
        n_cmp++;
        rstn = 1'b1;
        tick();
    endtask

    // Four samples of 1.0: bin0 v1 = 1,3,6,10, v2 = 6 -> re = 4*0.25 = 1.0 -> power 0x10000; bin1 -> 0.
    task automatic test_basic(input string tag);
        int n;
        pulse_start(16'd4);
        if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy: got %b want 1", tag, busy); end
        n_cmp++;
        for (int i = 0; i < 4; i++) send_sample(32'h0001_0000);
        wait_valid(n);
        if (n !== NBINS + 6) begin n_bad++; $display("FAIL %s_latency: got %0d want %0d", tag, n, NBINS + 6); end
        n_cmp++;
        if (bus.m_bin !== 1'b0) begin n_bad++; $display("FAIL %s_bin0_idx: got %h want 0", tag, bus.m_bin); end
        n_cmp++;
        if (bus.m_power !== 32'h0001_0000) begin n_bad++; $display("FAIL %s_bin0_pwr: got %h want 00010000", tag, bus.m_power); end
        n_cmp++;
        take();
        wait_valid(n);
        // n counts edges after the handshake edge; +1 counts the handshake cycle itself.
        if (n + 1 !== 7) begin n_bad++; $display("FAIL %s_bin_gap: got %0d want 7", tag, n + 1); end
        n_cmp++;
        if (bus.m_bin !== 1'b1) begin n_bad++; $display("FAIL %s_bin1_idx: got %h want 1", tag, bus.m_bin); end
        n_cmp++;
        if (bus.m_power !== 32'h0) begin n_bad++; $display("FAIL %s_bin1_pwr: got %h want 0", tag, bus.m_power); end
        n_cmp++;
        take();
        if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL %s_done: got done=%b busy=%b want 1/0", tag, done, busy); end
        n_cmp++;
        tick();
        if (done !== 1'b0) begin n_bad++; $display("FAIL %s_done_pulse: got %b want 0", tag, done); end
        n_cmp++;
    endtask

    task automatic test_backpressure();
        int n;
        pulse_start(16'd4);
        for (int i = 0; i < 4; i++) send_sample(32'h0001_0000);
        wait_valid(n);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.m_valid !== 1'b1 || bus.m_bin !== 1'b0 || bus.m_power !== 32'h0001_0000) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got v=%b bin=%h pwr=%h want 1/0/00010000", c, bus.m_valid, bus.m_bin, bus.m_power);
            end
            n_cmp++;
        end
        take();
        wait_valid(n);
        if (n + 1 !== 7) begin n_bad++; $display("FAIL bp_bin_gap: got %0d want 7", n + 1); end
        n_cmp++;
        if (bus.m_bin !== 1'b1 || bus.m_power !== 32'h0) begin n_bad++; $display("FAIL bp_bin1: got bin=%h pwr=%h want 1/0", bus.m_bin, bus.m_power); end
        n_cmp++;
        take();
        tick();
    endtask

    task automatic test_zero_len();
        bit saw_rdy = 1'b0;
        int n = 0;
        pulse_start(16'd0);
        while (!bus.m_valid && n < 100) begin
            saw_rdy |= bus.s_ready;
            tick(); n++;
        end
        if (saw_rdy !== 1'b0) begin n_bad++; $display("FAIL zero_s_ready: got %b want 0", saw_rdy); end
        n_cmp++;
        for (int b = 0; b < 2; b++) begin
            wait_valid(n);
            if (bus.m_bin !== b[0] || bus.m_power !== 32'h0) begin
                n_bad++;
                $display("FAIL zero_bin%0d: got bin=%h pwr=%h want %0d/0", b, bus.m_bin, bus.m_power, b);
            end
            n_cmp++;
            take();
        end
        tick();
    endtask

    task automatic test_reset_mid();
        pulse_start(16'd4);
        send_sample(32'h0001_0000);
        send_sample(32'h0001_0000);
        rstn = 1'b0;
        #1;
        if (busy !== 1'b0 || bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 || bus.m_power !== 32'h0 || bus.m_bin !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got busy=%b rdy=%b v=%b done=%b ovf=%b pwr=%h bin=%h want all 0",
                     busy, bus.s_ready, bus.m_valid, done, ovf, bus.m_power, bus.m_bin);
        end
        n_cmp++;
        tick(); tick();
        rstn = 1'b1;
        tick();
        test_basic("rerun");
    endtask

    task automatic test_start_busy();
        int n;
        pulse_start(16'd4);
        send_sample(32'h0001_0000);
        send_sample(32'h0001_0000);
        ns_i  = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_sample(32'h0001_0000);
        send_sample(32'h0001_0000);
        wait_valid(n);
        if (bus.m_bin !== 1'b0 || bus.m_power !== 32'h0001_0000) begin n_bad++; $display("FAIL sb_bin0: got bin=%h pwr=%h want 0/00010000", bus.m_bin, bus.m_power); end
        n_cmp++;
        take();
        wait_valid(n);
        if (bus.m_bin !== 1'b1 || bus.m_power !== 32'h0) begin n_bad++; $display("FAIL sb_bin1: got bin=%h pwr=%h want 1/0", bus.m_bin, bus.m_power); end
        n_cmp++;
        take();
        tick();
    endtask

    task automatic test_overflow();
        int n;
        logic [31:0] exp0, exp1;
        model_ovf = 1'b0;
        exp0 = model_bin(32'h0002_0000, 32'h0001_0000, 32'h0, 32'h7FFF_0000, 8, 32'h0000_4000);
        exp1 = model_bin(32'h0, 32'h0, 32'h0001_0000, 32'h7FFF_0000, 8, 32'h0000_4000);
        pulse_start(16'd8);
        for (int i = 0; i < 8; i++) send_sample(32'h7FFF_0000);
        wait_valid(n);
        if (bus.m_power !== exp0) begin n_bad++; $display("FAIL ovf_bin0_pwr: got %h want %h", bus.m_power, exp0); end
        n_cmp++;
        take();
        wait_valid(n);
        if (bus.m_power !== exp1) begin n_bad++; $display("FAIL ovf_bin1_pwr: got %h want %h", bus.m_power, exp1); end
        n_cmp++;
        take();
        if (ovf !== model_ovf) begin n_bad++; $display("FAIL ovf_flag: got %b want %b", ovf, model_ovf); end
        n_cmp++;
        tick();
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        test_reset();
        test_basic("basic");
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_start_busy();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end
endmodule
